// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/accumulate and radix-2 restoring divide with deferred HI/LO commit
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MX = MUL_LAT > WIDTH ? MUL_LAT : WIDTH;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] shadow, prod, acc;
    logic [WIDTH-1:0]   rem, quo, dvs, dnd;
    logic [WIDTH:0]     shifted, trial;
    logic               q_neg, r_neg, dz, ge;
    logic               is_mul, is_div, is_sgn, is_acc, is_sub, last;

    always_comb begin
        is_mul  = op == 4'd1 || op == 4'd2 || (op >= 4'd7 && op <= 4'd10);
        is_div  = op == 4'd3 || op == 4'd4;
        is_sgn  = op == 4'd2 || op == 4'd4 || op == 4'd8 || op == 4'd10;
        is_acc  = op >= 4'd7 && op <= 4'd10;
        is_sub  = op == 4'd9 || op == 4'd10;
        prod    = {{WIDTH{is_sgn & a[WIDTH-1]}}, a} * {{WIDTH{is_sgn & b[WIDTH-1]}}, b};
        acc     = is_sub ? {hi, lo} - prod : {hi, lo} + prod;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        ge      = shifted >= {1'b0, dvs};
        last    = cnt == CW'(1);
        busy    = state != IDLE;
        state_n = state;
        case (state)
            IDLE: state_n = start & is_mul ? MUL : start & is_div ? DIV : IDLE;
            MUL:  state_n = last ? IDLE : MUL;
            DIV:  state_n = last ? FIX : DIV;
            FIX:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (cancel)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            dnd    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (!cancel) begin
                case (state)
                    IDLE: begin
                        if (start & is_mul) begin
                            shadow <= is_acc ? acc : prod;
                            cnt    <= CW'(MUL_LAT);
                        end else if (start & is_div) begin
                            quo   <= is_sgn & a[WIDTH-1] ? -a : a;
                            dvs   <= is_sgn & b[WIDTH-1] ? -b : b;
                            rem   <= '0;
                            dnd   <= a;
                            q_neg <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg <= is_sgn & a[WIDTH-1];
                            dz    <= b == '0;
                            cnt   <= CW'(WIDTH);
                        end else if (op == 4'd5) begin
                            hi <= a;
                        end else if (op == 4'd6) begin
                            lo <= a;
                        end
                    end
                    MUL: begin
                        cnt <= cnt - CW'(1);
                        if (last) begin
                            {hi, lo} <= shadow;
                            done     <= 1'b1;
                        end
                    end
                    DIV: begin
                        cnt <= cnt - CW'(1);
                        rem <= ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ge};
                    end
                    FIX: begin
                        // divide-by-zero reports the raw dividend, not the signed-corrected remainder
                        lo   <= dz ? '1 : q_neg ? -quo : quo;
                        hi   <= dz ? dnd : r_neg ? -rem : rem;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random checks of mdu_iter against an arithmetic HI/LO model
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, hi, lo;
    logic [3:0]  op;
    logic        start, cancel, busy, done;
    logic [63:0] mhl;
    int          vectors = 0;
    int          errs = 0;

    mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [63:0] hl);
        longint sx, sy, ux, uy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            4'd1: return 64'(ux * uy);
            4'd2: return 64'(sx * sy);
            4'd7: return hl + 64'(ux * uy);
            4'd8: return hl + 64'(sx * sy);
            4'd9: return hl - 64'(ux * uy);
            4'd10: return hl - 64'(sx * sy);
            4'd3, 4'd4: begin
                if (y == 32'd0)
                    return {x, 32'hFFFFFFFF};
                q = o == 4'd3 ? ux / uy : sx / sy;
                r = o == 4'd3 ? ux % uy : sx % sy;
                return {r[31:0], q[31:0]};
            end
            4'd5: return {x, hl[31:0]};
            4'd6: return {hl[63:32], x};
            default: return hl;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] expv;
        int          n, lat;
        logic        held;
        expv = model(o, x, y, mhl);
        lat  = (o == 4'd3 || o == 4'd4) ? 33 : 5;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
        chk("busy_on_accept", {63'b0, busy}, 64'd1);
        n = 0;
        held = 1'b1;
        while (busy && n < 100) begin
            held &= ({hi, lo} === mhl) && !done;
            @(posedge clk); #1;
            n++;
        end
        chk("hilo_held_while_busy", {63'b0, held}, 64'd1);
        chk("latency", 64'(n), 64'(lat));
        chk("done_at_commit", {63'b0, done}, 64'd1);
        chk("result", {hi, lo}, expv);
        mhl = expv;
        @(posedge clk); #1;
        chk("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] x);
        @(negedge clk);
        op = o; a = x; start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        op = 4'd0; start = 1'b0;
        mhl = model(o, x, 32'd0, mhl);
        chk("mt_hilo", {hi, lo}, mhl);
        chk("mt_no_busy", {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] expv;
        logic        flag;
        int          n;
        logic [3:0]  o;
        logic [31:0] x, y;
        reset = 1'b1; a = '0; b = '0; op = '0; start = 1'b0; cancel = 1'b0;
        mhl = '0;
        #7;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_flags", {62'b0, busy, done}, 64'd0);
        @(negedge clk) reset = 1'b0;

        do_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
        do_op(4'd2, -32'sd3, 32'd7);
        chk("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        do_op(4'd3, 32'd100, 32'd7);
        chk("divu_const", {hi, lo}, {32'd2, 32'd14});
        do_op(4'd4, -32'sd7, 32'd2);
        chk("div_neg_dividend", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(4'd4, 32'd7, -32'sd2);
        chk("div_neg_divisor", {hi, lo}, 64'h00000001_FFFFFFFD);
        do_op(4'd3, 32'd5, 32'd0);
        chk("divu_by_zero", {hi, lo}, 64'h00000005_FFFFFFFF);
        do_op(4'd4, 32'h80000000, 32'hFFFFFFFF);
        chk("div_overflow", {hi, lo}, 64'h00000000_80000000);
        do_op(4'd4, 32'hFFFFFFF9, 32'd0);

        mt(4'd5, 32'd0);
        mt(4'd6, 32'd10);
        do_op(4'd7, 32'd3, 32'd4);
        chk("maddu_const", {hi, lo}, 64'd22);
        mt(4'd6, 32'd0);
        do_op(4'd10, 32'd1, 32'd1);
        chk("msub_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);

        // new requests hammered while busy must all be dropped
        expv = model(4'd1, 32'd2, 32'd3, mhl);
        @(negedge clk);
        op = 4'd1; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        flag = 1'b1;
        while (busy && n < 100) begin
            flag &= ({hi, lo} === mhl);
            op = n[0] ? 4'd6 : 4'd4; a = 32'hDEAD; b = 32'd2; start = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        op = 4'd0; start = 1'b0;
        chk("busy_ignore_hold", {63'b0, flag}, 64'd1);
        chk("busy_ignore_latency", 64'(n), 64'd5);
        chk("busy_ignore_result", {hi, lo}, expv);
        mhl = expv;

        // cancel a divide partway through
        @(negedge clk);
        op = 4'd4; a = -32'sd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        op = 4'd0; start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk) cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_flags", {62'b0, busy, done}, 64'd0);
        chk("cancel_hilo", {hi, lo}, mhl);
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            flag |= done | busy;
        end
        chk("cancel_no_late_done", {63'b0, flag}, 64'd0);
        do_op(4'd1, 32'h1234, 32'h5678);

        @(negedge clk);
        op = 4'd1; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        chk("cancel_start_busy", {63'b0, busy}, 64'd0);
        op = 4'd6; a = 32'd123; start = 1'b0;
        @(posedge clk); #1;
        cancel = 1'b0; op = 4'd0;
        chk("cancel_mtlo", {hi, lo}, mhl);

        // asynchronous reset between edges of a multiply
        @(negedge clk);
        op = 4'd1; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        op = 4'd0; start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        chk("async_reset_flags", {62'b0, busy, done}, 64'd0);
        mhl = '0;
        @(negedge clk) reset = 1'b0;
        do_op(4'd1, 32'd2, 32'd3);
        chk("post_reset_multu", {hi, lo}, 64'd6);

        repeat (60) begin
            o = 4'($urandom_range(1, 10));
            x = $urandom;
            y = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20));
            if ($urandom_range(0, 15) == 0) begin
                x = 32'h80000000; y = 32'hFFFFFFFF;
            end
            if (o == 4'd5 || o == 4'd6)
                mt(o, x);
            else
                do_op(o, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multi-cycle multiply/divide unit for the EX stage, successor to the fixed-latency MDU. It adds a configurable operand width, a true radix-2 iterative divider, multiply-accumulate/subtract modes, deferred HI/LO commit and a cancel input for exception flush. HI/LO hold their old values until an operation completes. The pipeline stalls on `busy` and reads `hi`/`lo` directly.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4.
- `MUL_LAT`, 5: multiply-class busy cycles; must be ≥ 1.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `a` input WIDTH: operand A (dividend/multiplicand; source for mthi/mtlo).
- `b` input WIDTH: operand B (divisor/multiplier).
- `op` input 4: 0 none, 1 multu, 2 mult, 3 divu, 4 div, 5 mthi, 6 mtlo, 7 maddu, 8 madd, 9 msubu, 10 msub; 11–15 treated as none.
- `start` input 1: qualifies ops 1–4 and 7–10.
- `cancel` input 1: synchronous flush of in-flight and same-cycle requests.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse on HI/LO commit.
- `hi`, `lo` output WIDTH: architectural HI/LO.

## Operation
- Reset (asynchronous): `hi`=0, `lo`=0, `busy`=0, `done`=0, counter and shadow registers cleared, FSM to IDLE.
- FSM states: IDLE, MUL (counting), DIV (iterating), FIX (divider sign correction and commit).
- IDLE, `start`=1, op ∈ {1,2,7–10}: latch the full 2·WIDTH product and load counter with MUL_LAT. Operands are unsigned for 1/7/9 and signed for 2/8/10. Enter MUL.
  - Accumulate ops: shadow = {hi,lo} ± product, mod 2^(2·WIDTH). The {hi,lo} used is the value at the accept edge.
- MUL: decrement each edge; on the edge counter goes 1→0, commit shadow to {hi,lo}, pulse `done`, return to IDLE.
- IDLE, `start`=1, op ∈ {3,4}: latch |a|, |b| and the quotient/remainder signs; enter DIV.
  - Signed magnitudes are used for op 4.
  - DIV: one restoring shift-subtract step per edge, WIDTH edges total, then FIX.
  - FIX: apply signs (quotient negative iff signs differ; remainder takes the dividend sign), commit `lo`=quotient and `hi`=remainder, pulse `done`, go to IDLE.
- Divide by zero: no trap. Result is `hi`=a, `lo`=all ones, with normal latency.
- div of −2^(WIDTH−1) by −1: `lo`=−2^(WIDTH−1), `hi`=0.
- op 5/6 in IDLE: `hi`/`lo` ← a at that edge, no busy, no done; `start` is ignored for these ops.
- Any op or start while `busy`=1 is ignored. The pipeline must stall.
- `cancel`=1 at an edge:
  - Aborts any in-flight operation and returns the FSM to IDLE; `busy`=0 from the next cycle.
  - No commit and no `done`; HI/LO keep their pre-operation values.
  - A same-edge start or mthi/mtlo is dropped; cancel wins.
- `reset` mid-operation: immediate asynchronous clear of all state.

## Timing
- Accept edge E: `busy`=1 from E until the commit edge.
- Multiply class: commit edge E+MUL_LAT, so `busy` is high for exactly MUL_LAT cycles.
- Divide class: commit edge E+WIDTH+1, so `busy` is high for WIDTH+1 cycles.
- At the commit edge, `busy` falls, `done` rises for one cycle, and new `hi`/`lo` are visible in the same cycle.
  - A new start is accepted at the very next edge.
- mthi/mtlo: zero latency; visible after the edge.
- `hi`/`lo` are registered outputs. `busy` and `done` are registered, with no combinational path from inputs.

## Test plan
- Multiply, WIDTH=32, MUL_LAT=5:
  - multu 0xFFFFFFFF×0xFFFFFFFF → `busy` high 5 cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` 1 cycle.
  - mult −3×7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Divide:
  - divu 100/7 → `busy` 33 cycles, then `lo`=14, `hi`=2.
  - div −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - div 7/−2 → `lo`=0xFFFFFFFD, `hi`=1.
- Corner cases:
  - divu 5/0 → `hi`=5, `lo`=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - Verify `hi`/`lo` remain at old values throughout busy.
- Accumulate:
  - mthi 0, mtlo 10, then maddu 3×4 → `lo`=22, `hi`=0.
  - msub 1×1 from {0,0} → `hi`=`lo`=0xFFFFFFFF.
- Handshake:
  - Issue start during busy → ignored.
  - mtlo during busy → `lo` unchanged.
  - cancel at cycle 10 of a div → `busy`=0 next cycle, no `done`, HI/LO unchanged; the next multu is accepted.
  - cancel+start on the same edge → nothing starts.
- Reset:
  - Assert `reset` asynchronously mid-multiply (between clock edges) → `hi`=`lo`=0 and `busy`=0 immediately.
  - Release `reset`, then multu 2×3 → `lo`=6 after 5 cycles.
